// File: rtl/controlador_multiplicacao_pkg.sv
// Shared definitions for the 5x5 int8 matrix-multiply host controller and its coprocessor:
// matrix geometry, FSM encoding and the element-offset helper.
package pacote_matriz;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int N_ELEM = DIM * DIM;
  localparam int MAT_W  = N_ELEM * ELEM_W;
  localparam int IDX_W  = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_WAIT   = ST_WAIT,
    S_STREAM = ST_STREAM
  } estado_t;

  // Bit offset of element idx (row-major r*DIM+c) inside a packed matrix bus.
  function automatic int elem_offset(input logic [IDX_W-1:0] idx);
    return int'(idx) * ELEM_W;
  endfunction

endpackage

// File: rtl/controlador_multiplicacao_serializador.sv
// Captures the 200-bit coprocessor result and streams its 25 bytes out in row-major
// order over a valid/ready handshake.
module serializador_resultado
  import pacote_matriz::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture,
  input  logic [MAT_W-1:0]  i_result,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ELEM_W-1:0] o_data,
  output logic              o_last,
  output logic              o_done
);

  logic [MAT_W-1:0] r_result;
  logic [IDX_W-1:0] r_index;
  logic             r_valid;
  logic             w_fire;
  logic             w_at_last;

  assign w_fire    = r_valid & i_ready;
  assign w_at_last = (r_index == IDX_W'(N_ELEM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_index  <= '0;
      r_valid  <= 1'b0;
    end else if (i_capture) begin
      r_result <= i_result;
      r_index  <= '0;
      r_valid  <= 1'b1;
    end else if (w_fire) begin
      if (w_at_last) begin
        r_valid <= 1'b0;
        r_index <= '0;
      end else begin
        r_index <= r_index + 1'b1;
      end
    end
  end

  // Data and last are masked when idle so stale results never leak onto the bus.
  assign o_valid = r_valid;
  assign o_data  = r_valid ? r_result[elem_offset(r_index) +: ELEM_W] : '0;
  assign o_last  = r_valid & w_at_last;
  assign o_done  = w_fire & w_at_last;

endmodule

// File: rtl/controlador_multiplicacao.sv
// Host-side initiator for the 5x5 int8 matrix coprocessor: byte-serial operand load,
// start/done handshake with timeout, and byte streaming of the captured result.
module controlador_multiplicacao
  import pacote_matriz::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic              go,
  output logic              busy,
  output logic              err,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              cop_start,
  output logic [MAT_W-1:0]  cop_matriz_a,
  output logic [MAT_W-1:0]  cop_matriz_b,
  input  logic [MAT_W-1:0]  cop_matriz_result,
  input  logic              cop_done,
  input  logic              cop_overflow
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  estado_t           r_state;
  estado_t           w_state_next;
  logic [ELEM_W-1:0] r_mat_a [N_ELEM];
  logic [ELEM_W-1:0] r_mat_b [N_ELEM];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_ovf;

  logic w_idle;
  logic w_go_ok;
  logic w_wr_ok;
  logic w_reject;
  logic w_done_wait;
  logic w_timeout;
  logic w_stream_done;

  assign w_idle      = (r_state == S_IDLE);
  assign w_go_ok     = w_idle & go;
  assign w_wr_ok     = w_idle & wr_en & (wr_addr < IDX_W'(N_ELEM));
  assign w_reject    = ~w_idle & (wr_en | go);
  assign w_done_wait = (r_state == S_WAIT) & cop_done;
  // Done on the final wait cycle still wins over the timeout.
  assign w_timeout   = (r_state == S_WAIT) & ~cop_done & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Operand registers only change in IDLE, so the buses stay stable for the whole run.
  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_operandos
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mat_a[gi] <= '0;
          r_mat_b[gi] <= '0;
        end else if (w_wr_ok && wr_addr == IDX_W'(gi)) begin
          if (wr_sel) r_mat_b[gi] <= wr_data;
          else        r_mat_a[gi] <= wr_data;
        end
      end
      assign cop_matriz_a[gi*ELEM_W +: ELEM_W] = r_mat_a[gi];
      assign cop_matriz_b[gi*ELEM_W +: ELEM_W] = r_mat_b[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    cop_start    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) w_state_next = S_START;
      end
      S_START: begin
        cop_start    = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_wait)    w_state_next = S_STREAM;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_STREAM: begin
        if (w_stream_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (r_state == S_START) r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_go_ok)                     r_err <= 1'b0;
      else if (w_timeout || w_reject) r_err <= 1'b1;
      if (w_go_ok)          r_ovf <= 1'b0;
      else if (w_done_wait) r_ovf <= cop_overflow;
    end
  end

  assign err = r_err;
  assign ovf = r_ovf;

  serializador_resultado u_serializador (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_done_wait),
    .i_result  (cop_matriz_result),
    .i_ready   (out_ready),
    .o_valid   (out_valid),
    .o_data    (out_data),
    .o_last    (out_last),
    .o_done    (w_stream_done)
  );

endmodule

// File: tb/tb_controlador_multiplicacao.sv
// Self-checking bench: table-driven operand sets, randomized runs against a matrix-product
// model, plus hand-written timeout, busy-access and reset corner cases.
module tb_controlador_multiplicacao;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en, wr_sel, go, out_ready, cop_done, cop_overflow;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         busy, err, ovf, out_valid, out_last, cop_start;
  logic [7:0]   out_data;
  logic [199:0] cop_matriz_a, cop_matriz_b, cop_matriz_result;

  controlador_multiplicacao #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go), .busy(busy), .err(err), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cop_start(cop_start), .cop_matriz_a(cop_matriz_a), .cop_matriz_b(cop_matriz_b),
    .cop_matriz_result(cop_matriz_result), .cop_done(cop_done), .cop_overflow(cop_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ea [25];
  logic [7:0] eb [25];
  logic [7:0] exp_bytes [25];
  bit         exp_ovf;

  typedef struct {
    bit         a_ident;
    logic [7:0] a_fill;
    bit         b_seq;
    logic [7:0] b_fill;
    logic [7:0] exp_base;
    logic [7:0] exp_step;
    bit         exp_ovf;
    int         lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [199:0] pack(input logic [7:0] m [25]);
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = m[i];
    return v;
  endfunction

  // Coprocessor behaviour: signed 5x5 product, low byte kept, overflow if any sum leaves int8.
  task automatic mat_mul(input logic [199:0] a, input logic [199:0] b,
                         output logic [199:0] c, output bit ov);
    ov = 1'b0;
    c  = '0;
    for (int r = 0; r < 5; r++) begin
      for (int cc = 0; cc < 5; cc++) begin
        int  s;
        byte av, bv;
        s = 0;
        for (int k = 0; k < 5; k++) begin
          av = a[(r*5+k)*8 +: 8];
          bv = b[(k*5+cc)*8 +: 8];
          s += int'(av) * int'(bv);
        end
        c[(r*5+cc)*8 +: 8] = s[7:0];
        if (s > 127 || s < -128) ov = 1'b1;
      end
    end
  endtask

  task automatic wr_byte(input bit sel, input int addr, input logic [7:0] data, input bit with_go);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = data; go = with_go;
    tick();
    wr_en = 1'b0; go = 1'b0;
  endtask

  task automatic load_ops(input bit go_on_last);
    for (int i = 0; i < 25; i++) wr_byte(1'b0, i, ea[i], 1'b0);
    for (int i = 0; i < 25; i++) wr_byte(1'b1, i, eb[i], go_on_last && i == 24);
  endtask

  task automatic run_op(input bit go_issued, input int lat, input int ready_pct, input string tag);
    logic [199:0] res;
    bit           ov;
    int           n;
    bit           prev_stall;
    logic [7:0]   prev_data;
    bit           rdy;
    if (!go_issued) begin
      go = 1'b1;
      tick();
      go = 1'b0;
    end
    chk({tag, " start_pulse"}, 32'(cop_start), 1);
    chk({tag, " busy_start"}, 32'(busy), 1);
    chk({tag, " err_cleared"}, 32'(err), 0);
    chk({tag, " ovf_cleared"}, 32'(ovf), 0);
    chk({tag, " bus_a"}, 32'(cop_matriz_a == pack(ea)), 1);
    chk({tag, " bus_b"}, 32'(cop_matriz_b == pack(eb)), 1);
    tick();
    chk({tag, " start_one_cycle"}, 32'(cop_start), 0);
    for (int i = 0; i < lat; i++) tick();
    mat_mul(cop_matriz_a, cop_matriz_b, res, ov);
    cop_matriz_result = res; cop_overflow = ov; cop_done = 1'b1;
    tick();
    cop_done = 1'b0; cop_matriz_result = ~res; cop_overflow = ~ov;
    chk({tag, " valid_after_done"}, 32'(out_valid), 1);
    chk({tag, " ovf_latched"}, 32'(ovf), 32'(exp_ovf));
    n = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 600 && n < 25; cyc++) begin
      if (prev_stall) begin
        chk($sformatf("%s stall_valid[%0d]", tag, n), 32'(out_valid), 1);
        chk($sformatf("%s stall_data[%0d]", tag, n), 32'(out_data), 32'(prev_data));
      end
      if (out_valid) begin
        rdy = ($urandom_range(99) < ready_pct);
        if (rdy) begin
          chk($sformatf("%s data[%0d]", tag, n), 32'(out_data), 32'(exp_bytes[n]));
          chk($sformatf("%s last[%0d]", tag, n), 32'(out_last), 32'(n == 24));
          n++;
        end
        prev_stall = !rdy;
        prev_data  = out_data;
      end else begin
        rdy = 1'($urandom_range(1));
        prev_stall = 1'b0;
      end
      out_ready = rdy;
      tick();
    end
    out_ready = 1'b0;
    chk({tag, " byte_count"}, 32'(n), 25);
    chk({tag, " valid_dropped"}, 32'(out_valid), 0);
    chk({tag, " busy_end"}, 32'(busy), 0);
    chk({tag, " ovf_hold"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, " err_end"}, 32'(err), 0);
    $display("run %s lat=%0d ready=%0d%% bytes=%0d ovf=%0b", tag, lat, ready_pct, n, ovf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [199:0] res;
    bit           ov;

    tbl[0] = '{a_ident:1, a_fill:8'h00, b_seq:1, b_fill:8'h00, exp_base:8'd1,  exp_step:8'd1, exp_ovf:0, lat:0};
    tbl[1] = '{a_ident:0, a_fill:8'd2,  b_seq:0, b_fill:8'd3,  exp_base:8'h1E, exp_step:8'd0, exp_ovf:0, lat:1};
    tbl[2] = '{a_ident:0, a_fill:8'd10, b_seq:0, b_fill:8'd10, exp_base:8'hF4, exp_step:8'd0, exp_ovf:1, lat:5};
    tbl[3] = '{a_ident:0, a_fill:8'hFF, b_seq:0, b_fill:8'd1,  exp_base:8'hFB, exp_step:8'd0, exp_ovf:0, lat:31};
    tbl[4] = '{a_ident:1, a_fill:8'h00, b_seq:0, b_fill:8'h80, exp_base:8'h80, exp_step:8'd0, exp_ovf:0, lat:63};

    rst_n = 1'b0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; go = 0;
    out_ready = 0; cop_done = 0; cop_overflow = 0; cop_matriz_result = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset busy", 32'(busy), 0);
    chk("reset err", 32'(err), 0);
    chk("reset ovf", 32'(ovf), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset cop_start", 32'(cop_start), 0);
    chk("reset bus_zero", 32'((cop_matriz_a | cop_matriz_b) == '0), 1);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 25; i++) begin
        ea[i] = tbl[t].a_ident ? ((i / 5 == i % 5) ? 8'd1 : 8'd0) : tbl[t].a_fill;
        eb[i] = tbl[t].b_seq ? 8'(i + 1) : tbl[t].b_fill;
        exp_bytes[i] = 8'(tbl[t].exp_base + tbl[t].exp_step * 8'(i));
      end
      exp_ovf = tbl[t].exp_ovf;
      load_ops(1'b0);
      run_op(1'b0, tbl[t].lat, 100, $sformatf("vec%0d", t));
    end

    // Coprocessor that never answers: timeout, then a late done must be ignored.
    go = 1'b1; tick(); go = 1'b0;
    chk("tmo start_pulse", 32'(cop_start), 1);
    tick();
    chk("tmo start_one_cycle", 32'(cop_start), 0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (out_valid) chk($sformatf("tmo no_valid[%0d]", k), 32'(out_valid), 0);
      if (k == 63) begin
        chk("tmo busy_before", 32'(busy), 1);
        chk("tmo err_before", 32'(err), 0);
      end
    end
    chk("tmo busy_after", 32'(busy), 0);
    chk("tmo err_after", 32'(err), 1);
    chk("tmo ovf_unchanged", 32'(ovf), 0);
    cop_matriz_result = {200{1'b1}}; cop_overflow = 1'b1; cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    chk("late_done valid", 32'(out_valid), 0);
    chk("late_done busy", 32'(busy), 0);
    chk("late_done ovf", 32'(ovf), 0);
    chk("late_done err_sticky", 32'(err), 1);
    $display("run timeout err=%0b busy=%0b", err, busy);

    // Randomized operands, 30% ready; the first runs issue go together with the last write.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 25; i++) begin
        ea[i] = (r % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
        eb[i] = (r % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      end
      mat_mul(pack(ea), pack(eb), res, ov);
      for (int i = 0; i < 25; i++) exp_bytes[i] = res[i*8 +: 8];
      exp_ovf = ov;
      load_ops(r < 2);
      run_op(r < 2, int'($urandom_range(0, 40)), 30, $sformatf("rnd%0d", r));
    end

    // Writes and go while busy are rejected; reset mid-wait drops everything.
    for (int i = 0; i < 25; i++) begin
      ea[i] = (i == 0) ? 8'h05 : 8'h00;
      eb[i] = 8'h00;
    end
    load_ops(1'b0);
    go = 1'b1; tick(); go = 1'b0;
    tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'h7F; go = 1'b1;
    tick();
    wr_en = 1'b0; go = 1'b0;
    chk("busy_access err", 32'(err), 1);
    chk("busy_access still_busy", 32'(busy), 1);
    chk("busy_access a0_kept", 32'(cop_matriz_a[7:0]), 32'h05);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_reset busy", 32'(busy), 0);
    chk("mid_reset err", 32'(err), 0);
    chk("mid_reset bus_a", 32'(cop_matriz_a == '0), 1);
    tick();
    rst_n = 1'b1;
    tick();
    cop_matriz_result = {200{1'b1}}; cop_overflow = 1'b1; cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    chk("post_reset_done busy", 32'(busy), 0);
    chk("post_reset_done valid", 32'(out_valid), 0);
    chk("post_reset_done data", 32'(out_data), 0);
    chk("post_reset_done last", 32'(out_last), 0);
    chk("post_reset_done ovf", 32'(ovf), 0);
    chk("post_reset_done err", 32'(err), 0);
    chk("post_reset_done start", 32'(cop_start), 0);
    $display("run reset_mid_wait busy=%0b out_valid=%0b", busy, out_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
